serial_adder_ctrl: RTL and testbench

Bit-serial adder sequencer. It time-multiplexes a single `fulladder_element` instance across the bits of a WIDTH-bit addition. Operands are accepted over a valid/ready handshake and fed LSB-first, one bit per clock, with the carry held in a flop between bits. The result is presented on a second valid/ready handshake. It is the area-minimal adder option for the arithmetic library, trading WIDTH cycles of latency for one full adder.

---
 rtl/serial_adder_ctrl_if.sv | 28 ++
 rtl/serial_adder_ctrl.sv | 148 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// master = operand producer / result consumer, slave = the controller.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one fulladder_element reused LSB-first over WIDTH cycles.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN.
module fulladder_element #(
    parameter int LEVEL = 2
) (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    generate
        if (LEVEL == 3) begin : g_behav
            always_comb begin
                {co, s} = {1'b0, a} + {1'b0, b} + {1'b0, c};
            end
        end else if (LEVEL == 2) begin : g_rtl
            always_comb begin
                s  = a ^ b ^ c;
                co = (a & b) | (c & (a ^ b));
            end
        end else begin : g_gate
            logic x1, n1, n2;
            xor u_x1 (x1, a, b);
            xor u_x2 (s, x1, c);
            and u_a1 (n1, a, b);
            and u_a2 (n2, x1, c);
            or  u_o1 (co, n1, n2);
        end
    endgenerate
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int LEVEL = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, ss, sum_q;
    logic [WIDTH-1:0] ss_nx;
    logic [WIDTH:0]   ss_ext;
    logic [CW-1:0]    cnt;
    logic             carry, cout_q, ovf_q;
    logic             fa_b, fa_s, fa_co;
    logic             last;

`ifdef SERIAL_ADDER_SUB_EN
    logic             subr;
    assign fa_b = sb[0] ^ subr;
`else
    logic             unused_sub;
    assign unused_sub = bus.sub;
    assign fa_b       = sb[0];
`endif

    fulladder_element #(.LEVEL(LEVEL)) u_fa (
        .a  (sa[0]),
        .b  (fa_b),
        .c  (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last   = (cnt == CW'(WIDTH - 1));
    // Shift the new sum bit in at the MSB; written so WIDTH=1 needs no special case.
    assign ss_ext = {fa_s, ss} >> 1;
    assign ss_nx  = ss_ext[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nx = RUN;
            RUN:     if (last)          state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            ss     <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            subr   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sa    <= bus.a;
                        sb    <= bus.b;
                        ss    <= '0;
                        cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        subr  <= bus.sub;
                        carry <= bus.sub ? 1'b1 : bus.cin;
`else
                        carry <= bus.cin;
`endif
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    ss    <= ss_nx;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    // Result registers load only at DONE entry, so they hold through the next RUN.
                    if (last) begin
                        sum_q  <= ss_nx;
                        cout_q <= fa_co;
                        ovf_q  <= carry ^ fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench: directed vectors on a WIDTH=8 instance plus random
// a+b+cin traffic on WIDTH 1/8/13 x LEVEL 1/2/3 instances.
module tb_serial_adder_ctrl;
    logic clk;
    logic rst;
    logic rrst;
    bit   go;
    int   checks;
    int   fails;
    int   hs_cnt;
    int   rdone;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    serial_adder_ctrl_if #(.WIDTH(8)) dbus ();
    serial_adder_ctrl #(.WIDTH(8), .LEVEL(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dbus)
    );

    logic [9:0] dq[$];

    always @(negedge clk) begin
        if (!rst && dbus.out_valid && dbus.out_ready) begin
            logic [9:0] e;
            hs_cnt++;
            if (dq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL dut8_unexpected_result: got sum %0h expected no output", dbus.sum);
            end else begin
                e = dq.pop_front();
                chk("dut8_sum",  32'(dbus.sum),  32'(e[9:2]));
                chk("dut8_cout", 32'(dbus.cout), 32'(e[1]));
                chk("dut8_ovf",  32'(dbus.ovf),  32'(e[0]));
            end
        end
    end

    task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic vc, input logic vs,
                        input logic [7:0] es, input logic ec, input logic eo, input bit push);
        int t;
        dbus.a = va;
        dbus.b = vb;
        dbus.cin = vc;
        dbus.sub = vs;
        dbus.in_valid = 1'b1;
        t = 0;
        while (!dbus.in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) begin
            checks++;
            fails++;
            $display("FAIL dut8_accept_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk); #1;
        dbus.in_valid = 1'b0;
        if (push) dq.push_back({es, ec, eo});
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (dq.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("dut8_drain_pending", 32'(dq.size()), 32'd0);
    endtask

    genvar gl, gw;
    generate
        for (gl = 1; gl <= 3; gl++) begin : g_lv
            for (gw = 0; gw < 3; gw++) begin : g_w
                localparam int W = (gw == 0) ? 1 : ((gw == 1) ? 8 : 13);
                serial_adder_ctrl_if #(.WIDTH(W)) rb ();
                serial_adder_ctrl #(.WIDTH(W), .LEVEL(gl)) u_r (
                    .clk (clk),
                    .rst (rrst),
                    .bus (rb)
                );
                logic [W+1:0] q[$];

                initial begin
                    logic [W-1:0] ra, rbv, es;
                    logic         rc, eo;
                    logic [W:0]   full;
                    int           t;
                    rb.in_valid = 1'b0;
                    rb.a = '0;
                    rb.b = '0;
                    rb.cin = 1'b0;
                    rb.sub = 1'b0;
                    wait (go);
                    for (int n = 0; n < 1000; n++) begin
                        ra  = W'($urandom);
                        rbv = W'($urandom);
                        rc  = 1'($urandom);
                        @(posedge clk); #1;
                        rb.a = ra;
                        rb.b = rbv;
                        rb.cin = rc;
                        rb.in_valid = 1'b1;
                        t = 0;
                        while (!rb.in_ready && t < 100) begin
                            @(posedge clk); #1;
                            t++;
                        end
                        if (t >= 100) begin
                            checks++;
                            fails++;
                            $display("FAIL rand_L%0d_W%0d_accept_timeout: in_ready got 0 expected 1", gl, W);
                            break;
                        end
                        @(posedge clk); #1;
                        rb.in_valid = 1'b0;
                        full = {1'b0, ra} + {1'b0, rbv} + {{W{1'b0}}, rc};
                        es   = full[W-1:0];
                        eo   = (ra[W-1] == rbv[W-1]) && (es[W-1] != ra[W-1]);
                        q.push_back({es, full[W], eo});
                    end
                    t = 0;
                    while (q.size() != 0 && t < 200) begin
                        @(posedge clk); #1;
                        t++;
                    end
                    chk($sformatf("rand_L%0d_W%0d_drain", gl, W), 32'(q.size()), 32'd0);
                    rdone++;
                end

                initial begin
                    rb.out_ready = 1'b1;
                    forever begin
                        @(posedge clk); #1;
                        rb.out_ready = ($urandom_range(0, 3) != 0);
                    end
                end

                always @(negedge clk) begin
                    if (!rrst && rb.out_valid && rb.out_ready) begin
                        if (q.size() == 0) begin
                            checks++;
                            fails++;
                            $display("FAIL rand_L%0d_W%0d_unexpected: got %0h expected no output", gl, W, rb.sum);
                        end else begin
                            chk($sformatf("rand_L%0d_W%0d_result", gl, W),
                                32'({rb.sum, rb.cout, rb.ovf}), 32'(q.pop_front()));
                        end
                    end
                end
            end
        end
    endgenerate

    initial begin
        int t;
        int hs0;
        rst = 1'b0;
        rrst = 1'b0;
        go = 1'b0;
        checks = 0;
        fails = 0;
        hs_cnt = 0;
        rdone = 0;
        dbus.in_valid = 1'b0;
        dbus.a = '0;
        dbus.b = '0;
        dbus.cin = 1'b0;
        dbus.sub = 1'b0;
        dbus.out_ready = 1'b1;
        #1;
        rst = 1'b1;
        rrst = 1'b1;
        #1;
        chk("reset_in_ready",  32'(dbus.in_ready),  32'd1);
        chk("reset_out_valid", 32'(dbus.out_valid), 32'd0);
        chk("reset_busy",      32'(dbus.busy),      32'd0);
        chk("reset_sum",       32'(dbus.sum),       32'd0);
        chk("reset_cout",      32'(dbus.cout),      32'd0);
        chk("reset_ovf",       32'(dbus.ovf),       32'd0);
        #20;
        @(negedge clk);
        rst = 1'b0;
        rrst = 1'b0;
        go = 1'b1;
        @(posedge clk); #1;

        send(8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        t = 0;
        while (!dbus.out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("latency_edges", 32'(t), 32'd8);

        send(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        send(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
        send(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
`else
        send(8'h05, 8'h07, 1'b1, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b1);
`endif
        drain();

        dbus.out_ready = 1'b0;
        send(8'h22, 8'h33, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        t = 0;
        while (!dbus.out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            dbus.a = 8'h11;
            dbus.b = 8'h11;
            dbus.in_valid = 1'b1;
            chk("hold_sum",       32'(dbus.sum),       32'h55);
            chk("hold_in_ready",  32'(dbus.in_ready),  32'd0);
            chk("hold_out_valid", 32'(dbus.out_valid), 32'd1);
            @(posedge clk); #1;
        end
        dbus.in_valid = 1'b0;
        hs0 = hs_cnt;
        dbus.out_ready = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        chk("hold_release_handshakes", 32'(hs_cnt - hs0), 32'd1);
        chk("after_hs_sum_kept",       32'(dbus.sum),       32'h55);
        chk("after_hs_out_valid",      32'(dbus.out_valid), 32'd0);
        chk("after_hs_in_ready",       32'(dbus.in_ready),  32'd1);

        send(8'h0F, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_busy",      32'(dbus.busy),      32'd0);
        chk("abort_in_ready",  32'(dbus.in_ready),  32'd1);
        chk("abort_out_valid", 32'(dbus.out_valid), 32'd0);
        chk("abort_sum",       32'(dbus.sum),       32'd0);
        chk("abort_cout",      32'(dbus.cout),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        send(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
        drain();
        chk("handshake_total", 32'(hs_cnt), 32'd6);

        t = 0;
        while (rdone < 9 && t < 60000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("random_blocks_done", 32'(rdone), 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
